// File: rtl/cp0_exc_unit_pkg.sv
// CP0 register numbers, exception codes and Status/Cause field positions
// shared by the exception unit and its timer.
package cp0_defs;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  localparam int unsigned IE_BIT  = 0;
  localparam int unsigned EXL_BIT = 1;
  localparam int unsigned IM_LSB  = 8;
  localparam int unsigned IP_LSB  = 8;
  localparam int unsigned EXC_LSB = 2;
  localparam int unsigned BD_BIT  = 31;
  localparam int unsigned TI_BIT  = 30;

  // Cause bits software may write: IV, WP and the two software interrupts.
  localparam logic [31:0] CAUSE_WMASK = 32'h00C00300;

endpackage

// File: rtl/cp0_exc_unit_timer.sv
// Count/Compare timer: Count advances once per COUNT_DIV clocks; TI is a sticky
// match flag cleared only by a Compare write.
module cp0_timer
  import cp0_defs::*;
#(
  parameter int unsigned COUNT_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d, compare_q, compare_d, count_inc;
  logic          ti_q, ti_d, wrap;

  assign wrap      = (presc_q == PW'(COUNT_DIV - 1));
  assign count_inc = count_q + 32'd1;

  always_comb begin
    presc_d   = wrap ? '0 : presc_q + PW'(1);
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    // A freshly loaded Count is not matched; only an increment can raise TI.
    if (count_we_i) begin
      count_d = wdata_i;
      presc_d = '0;
    end else if (wrap) begin
      count_d = count_inc;
      if (count_inc == compare_q && compare_q != 32'd0) ti_d = 1'b1;
    end
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 beside MEM/WB: Status/Cause/EPC/BadVAddr, MFC0/MTC0 access, exception and
// ERET commit, interrupt request and flush redirect target.
module cp0_exc_unit
  import cp0_defs::*;
#(
  parameter int unsigned HW_INT_NUM   = 6,
  parameter int unsigned COUNT_DIV    = 1,
  parameter logic [31:0] PRID_VAL     = 32'h004C0102,
  parameter logic [31:0] CONFIG_VAL   = 32'h00008000,
  parameter logic [31:0] STATUS_RST   = 32'h10000000,
  parameter logic [31:0] STATUS_WMASK = 32'h1000FF03,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [4:0]            raddr_i,
  output logic [31:0]           rdata_o,
  input  logic [HW_INT_NUM-1:0] hw_int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           exc_badvaddr_i,
  input  logic                  eret_i,
  input  logic [31:0]           pc_i,
  input  logic                  in_delay_i,
  output logic                  int_req_o,
  output logic                  flush_o,
  output logic [31:0]           target_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);

  logic [31:0]           status_q, status_d, cause_q, cause_d, epc_q, epc_d;
  logic [31:0]           badv_q, badv_d, cause_val, count, compare;
  logic [HW_INT_NUM-1:0] hw_ip_q;
  logic [5:0]            hw6;
  logic                  ti, wr_status, wr_cause, wr_epc;

  assign wr_status = we_i && (waddr_i == REG_STATUS);
  assign wr_cause  = we_i && (waddr_i == REG_CAUSE);
  assign wr_epc    = we_i && (waddr_i == REG_EPC);

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .count_we_i   (we_i && (waddr_i == REG_COUNT)),
    .compare_we_i (we_i && (waddr_i == REG_COMPARE)),
    .wdata_i      (wdata_i),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  // cause_q only stores software/exception fields; IP and TI are overlaid here.
  assign hw6 = 6'(hw_ip_q);
  always_comb begin
    cause_val                  = cause_q;
    cause_val[IP_LSB+2 +: 6]   = hw6;
    cause_val[IP_LSB+7]        = hw6[5] | ti;
    cause_val[TI_BIT]          = ti;
  end

  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    badv_d   = badv_q;
    if (wr_status) status_d = (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
    if (wr_cause)  cause_d  = (cause_q & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
    if (wr_epc)    epc_d    = wdata_i;
    // Exception fields override any same-cycle MTC0; a concurrent ERET is dropped.
    if (exc_valid_i) begin
      if (!status_q[EXL_BIT]) begin
        epc_d          = in_delay_i ? pc_i - 32'd4 : pc_i;
        cause_d[BD_BIT] = in_delay_i;
      end
      cause_d[EXC_LSB +: 5] = exc_code_i;
      status_d[EXL_BIT]     = 1'b1;
      if (exc_code_i == EXC_ADEL || exc_code_i == EXC_ADES) badv_d = exc_badvaddr_i;
    end else if (eret_i) begin
      status_d[EXL_BIT] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= STATUS_RST;
      cause_q  <= '0;
      epc_q    <= '0;
      badv_q   <= '0;
      hw_ip_q  <= '0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      badv_q   <= badv_d;
      hw_ip_q  <= hw_int_i;
    end
  end

  always_comb begin
    case (raddr_i)
      REG_BADVADDR: rdata_o = badv_q;
      REG_COUNT:    rdata_o = count;
      REG_COMPARE:  rdata_o = compare;
      REG_STATUS:   rdata_o = status_q;
      REG_CAUSE:    rdata_o = cause_val;
      REG_EPC:      rdata_o = epc_q;
      REG_PRID:     rdata_o = PRID_VAL;
      REG_CONFIG:   rdata_o = CONFIG_VAL;
      default:      rdata_o = '0;
    endcase
  end

  assign int_req_o = (|(cause_val[IP_LSB +: 8] & status_q[IM_LSB +: 8]))
                     & status_q[IE_BIT] & ~status_q[EXL_BIT];
  assign flush_o   = exc_valid_i | eret_i;
  assign target_o  = (eret_i && !exc_valid_i) ? epc_q : EXC_VECTOR;
  assign status_o  = status_q;
  assign cause_o   = cause_val;
  assign epc_o     = epc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit (COUNT_DIV=2); expectations are queued at
// stimulus time and retired in order against MFC0 reads and outputs.
module tb_cp0_exc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we_i;
  logic [4:0]  waddr_i, raddr_i, exc_code_i;
  logic [31:0] wdata_i, rdata_o, exc_badvaddr_i, pc_i, target_o, status_o, cause_o, epc_o;
  logic [5:0]  hw_int_i;
  logic        exc_valid_i, eret_i, in_delay_i, int_req_o, flush_o;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  cp0_exc_unit #(.HW_INT_NUM(6), .COUNT_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .hw_int_i(hw_int_i),
    .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_badvaddr_i(exc_badvaddr_i),
    .eret_i(eret_i), .pc_i(pc_i), .in_delay_i(in_delay_i), .int_req_o(int_req_o),
    .flush_o(flush_o), .target_o(target_o), .status_o(status_o), .cause_o(cause_o),
    .epc_o(epc_o)
  );

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  task automatic check_reg(input logic [4:0] a);
    raddr_i = a;
    #1;
    check(rdata_o);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    @(negedge clk);
    we_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0;
    hw_int_i = '0; exc_valid_i = 1'b0; exc_code_i = '0; exc_badvaddr_i = '0;
    eret_i = 1'b0; pc_i = '0; in_delay_i = 1'b0;

    // Reset state
    step(2);
    expect_val("rst_count", 32'd0);         check_reg(5'd9);
    expect_val("rst_status", 32'h10000000); check_reg(5'd12);
    expect_val("rst_cause", 32'd0);         check_reg(5'd13);
    expect_val("rst_int_req", 32'd0);       check({31'd0, int_req_o});
    step(1);
    expect_val("rst_epc", 32'd0);           check_reg(5'd14);
    expect_val("prid", 32'h004C0102);       check_reg(5'd15);
    expect_val("config", 32'h00008000);     check_reg(5'd16);
    expect_val("unimpl_rd", 32'd0);         check_reg(5'd3);

    // Test 1: prescaled Count and 32-bit wrap
    rst_n = 1'b1;
    expect_val("count_div2", 32'd5);
    step(10);
    check_reg(5'd9);
    expect_val("count_load", 32'hFFFFFFFF);
    expect_val("count_wrap", 32'd0);
    mtc0(5'd9, 32'hFFFFFFFF);
    check_reg(5'd9);
    step(2);
    check_reg(5'd9);

    // Test 2: Compare match, sticky TI, interrupt, clear by Compare write
    mtc0(5'd11, 32'd20);
    mtc0(5'd9, 32'd0);
    expect_val("count_19", 32'd19);
    expect_val("ti_before", 32'd0);
    step(39);
    check_reg(5'd9);
    check_reg(5'd13);
    expect_val("count_20", 32'd20);
    expect_val("ti_set", 32'h40008000);
    step(1);
    check_reg(5'd9);
    check_reg(5'd13);
    expect_val("status_im7_ie", 32'h10008001);
    expect_val("int_req_timer", 32'd1);
    mtc0(5'd12, 32'h10008001);
    check_reg(5'd12);
    check({31'd0, int_req_o});
    expect_val("ti_cleared", 32'd0);
    expect_val("int_req_clr", 32'd0);
    mtc0(5'd11, 32'd0);
    check_reg(5'd13);
    check({31'd0, int_req_o});
    mtc0(5'd12, 32'h10000000);

    // Test 3: Sys in delay slot with EXL=0
    exc_valid_i = 1'b1; exc_code_i = 5'd8; pc_i = 32'h80000104; in_delay_i = 1'b1;
    expect_val("flush_exc", 32'd1);
    expect_val("target_vec", 32'hBFC00380);
    expect_val("epc_sys", 32'h80000100);
    expect_val("cause_sys", 32'h80000020);
    expect_val("status_exl", 32'h10000002);
    expect_val("epc_o_sys", 32'h80000100);
    #1;
    check({31'd0, flush_o});
    check(target_o);
    @(negedge clk);
    exc_valid_i = 1'b0; in_delay_i = 1'b0;
    check_reg(5'd14);
    check_reg(5'd13);
    check_reg(5'd12);
    check(epc_o);

    // Test 4: nested Ov keeps EPC/BD, then ERET returns to EPC
    exc_valid_i = 1'b1; exc_code_i = 5'd12; pc_i = 32'h00000200;
    expect_val("epc_hold", 32'h80000100);
    expect_val("cause_ov", 32'h80000030);
    @(negedge clk);
    exc_valid_i = 1'b0;
    check_reg(5'd14);
    check_reg(5'd13);
    eret_i = 1'b1;
    expect_val("target_eret", 32'h80000100);
    expect_val("status_eret", 32'h10000000);
    #1;
    check(target_o);
    @(negedge clk);
    eret_i = 1'b0;
    check_reg(5'd12);

    // Test 5: AdEL + MTC0 Status=0 + ERET in one cycle
    exc_valid_i = 1'b1; exc_code_i = 5'd4; exc_badvaddr_i = 32'h00001003;
    pc_i = 32'h00000300; eret_i = 1'b1;
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'd0;
    expect_val("target_exc_wins", 32'hBFC00380);
    expect_val("badvaddr", 32'h00001003);
    expect_val("status_mtc0_exc", 32'h00000002);
    expect_val("epc_adel", 32'h00000300);
    expect_val("cause_adel", 32'h00000010);
    #1;
    check(target_o);
    @(negedge clk);
    exc_valid_i = 1'b0; eret_i = 1'b0; we_i = 1'b0;
    check_reg(5'd8);
    check_reg(5'd12);
    check_reg(5'd14);
    check_reg(5'd13);

    // Test 6: hardware interrupt, then asynchronous reset mid-run
    eret_i = 1'b1;
    @(negedge clk);
    eret_i = 1'b0;
    hw_int_i = 6'b000100;
    expect_val("status_im4", 32'h00001001);
    expect_val("int_req_hw", 32'd1);
    expect_val("cause_ip4", 32'h00001010);
    mtc0(5'd12, 32'h00001001);
    check_reg(5'd12);
    check({31'd0, int_req_o});
    check(cause_o);
    #2;
    rst_n = 1'b0;
    expect_val("int_req_rst", 32'd0);
    expect_val("status_rst", 32'h10000000);
    expect_val("count_rst", 32'd0);
    expect_val("cause_rst", 32'd0);
    #1;
    check({31'd0, int_req_o});
    check(status_o);
    check_reg(5'd9);
    check(cause_o);
    step(2);
    rst_n = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
